// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, LSB first.
// Emits one-cycle data_valid on a good stop bit, one-cycle frame_err on a bad one.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 1250,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_o,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_param
    $error("uart_rx: CLKS_PER_BIT must be >= 4");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             rx_meta;
  logic             rx_s;

  // Line synchroniser; resets to the idle (high) level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM with registered outputs; strobes default low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      data_o     <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (baud_cnt == HALF_END) begin
            baud_cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (baud_cnt == BIT_END) begin
            baud_cnt <= '0;
            shift    <= {rx_s, shift[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (baud_cnt == BIT_END) begin
            baud_cnt <= '0;
            if (rx_s) begin
              data_o     <= shift;
              data_valid <= 1'b1;
              state      <= IDLE;
              busy       <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        WAIT_IDLE: begin
          baud_cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at CLKS_PER_BIT=16: the driver queues expected
// events per frame, a negedge monitor pops and checks them as the DUT strobes.
module tb_uart_rx;

  localparam int unsigned CPB  = 16;
  localparam int unsigned HALF = 8;
  localparam int          LAT  = 2 + HALF + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] data_o;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         start;
  } exp_t;

  exp_t sb[$];
  int   dv_cyc[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic prev_dv = 1'b0;
  logic prev_fe = 1'b0;
  logic [7:0] last_good = 8'h00;

  uart_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data_o(data_o),
    .data_valid(data_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (data_valid === 1'b1 || frame_err === 1'b1)) begin
      exp_t e;
      chk("strobe_exclusive", int'(data_valid & frame_err), 0);
      chk("strobe_width", int'(prev_dv | prev_fe), 0);
      if (sb.size() == 0) begin
        chk("unexpected_strobe", int'({data_valid, frame_err}), 0);
      end else begin
        e = sb.pop_front();
        chk("event_kind_err", int'(frame_err), int'(e.is_err));
        chk("data_o", int'(data_o), int'(e.data));
        chk_rng("latency", cyc - e.start, LAT - 1, LAT + 1);
      end
      if (data_valid === 1'b1) dv_cyc.push_back(cyc);
    end
    prev_dv <= data_valid;
    prev_fe <= frame_err;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_bits(input int n);
    repeat (n * CPB) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  // Drive one frame; queue the expected strobe. Optionally count busy-low cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop, output int busy_low);
    logic [9:0] bits;
    exp_t e;
    int st;
    bits = {stop, b, 1'b0};
    busy_low = 0;
    st = 0;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < int'(CPB); j++) begin
        @(negedge clk);
        rx = bits[i];
        if (i == 0 && j == 0) begin
          st = cyc;
          e.is_err = ~stop;
          e.data = stop ? b : last_good;
          e.start = st;
          sb.push_back(e);
          if (stop) last_good = b;
        end
        if ((cyc - st) >= 4 && (cyc - st) <= LAT - 5 && busy !== 1'b1) busy_low++;
      end
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int bl;
    int n;
    rx = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_data_o", int'(data_o), 0);
    chk("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    idle_bits(1);
    chk("idle_after_reset", int'({data_valid, frame_err, busy}), 0);

    // Clean 0xA5; busy must stay high through the frame.
    send_frame(8'hA5, 1'b1, bl);
    chk("busy_during_frame", bl, 0);
    idle_bits(1);
    drain("drain_a5");
    chk("data_o_hold_a5", int'(data_o), 8'hA5);

    // Back-to-back 0x00, 0xFF without idle gap.
    dv_cyc.delete();
    send_frame(8'h00, 1'b1, bl);
    send_frame(8'hFF, 1'b1, bl);
    idle_bits(1);
    drain("drain_b2b");
    chk("b2b_count", dv_cyc.size(), 2);
    if (dv_cyc.size() == 2) chk_rng("b2b_gap", dv_cyc[1] - dv_cyc[0], 159, 161);
    chk("data_o_hold_ff", int'(data_o), 8'hFF);

    // Glitch: 5 low cycles must be rejected.
    repeat (5) begin
      @(negedge clk);
      rx = 1'b0;
    end
    @(negedge clk);
    rx = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 6) begin
      @(negedge clk);
      n++;
    end
    chk("glitch_busy_rise", int'(busy), 1);
    n = 0;
    while (busy !== 1'b0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk_rng("glitch_busy_fall", n, 0, HALF + 3);
    idle_bits(2);
    chk("glitch_data_o", int'(data_o), 8'hFF);

    // Good 0x11, then 0x3C with a low stop bit.
    send_frame(8'h11, 1'b1, bl);
    idle_bits(1);
    send_frame(8'h3C, 1'b0, bl);
    idle_bits(2);
    drain("drain_stop_err");
    chk("data_o_after_ferr", int'(data_o), 8'h11);

    // Break: 40 bit times low gives one frame_err, then a clean 0x5A.
    begin
      exp_t e;
      @(negedge clk);
      rx = 1'b0;
      e.is_err = 1'b1;
      e.data = last_good;
      e.start = cyc;
      sb.push_back(e);
      repeat (40 * CPB - 1) @(negedge clk);
    end
    idle_bits(2);
    send_frame(8'h5A, 1'b1, bl);
    idle_bits(1);
    drain("drain_break");
    chk("data_o_after_break", int'(data_o), 8'h5A);

    // Reset in the middle of DATA, with the line high during reset.
    repeat (CPB) begin
      @(negedge clk);
      rx = 1'b0;
    end
    repeat (2 * CPB) @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    chk("busy_mid_data", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_data_o", int'(data_o), 0);
    chk("rst_strobes_busy", int'({data_valid, frame_err, busy}), 0);
    repeat (3) @(negedge clk);
    chk("rst_hold", int'({data_o, data_valid, frame_err, busy}), 0);
    rst_n = 1'b1;
    last_good = 8'h00;
    idle_bits(2);
    send_frame(8'hC3, 1'b1, bl);
    idle_bits(1);
    drain("drain_c3");
    chk("data_o_after_rst", int'(data_o), 8'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
